// File: rtl/mips_pkg.sv
// mips_pkg: shared states and constants for the MIPS unified-memory arbiter.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_DM = 2'd1,
        GRANT_IF = 2'd2,
        RESP     = 2'd3
    } mem_arb_state_t;

    localparam logic        GRANT_IF_ID = 1'b0;
    localparam logic        GRANT_DM_ID = 1'b1;
    localparam logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts stalled grant cycles and pulses expire on the last allowed one.
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Firing on the final stalled cycle lets the FSM leave GRANT exactly TIMEOUT_CYCLES cycles in.
    assign expire = en & (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-ported memory between fetch and load/store, data first but fair.
// Optional grant watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mips_mem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              timeout_err
);

    mem_arb_state_t    state, state_nx;
    logic              last_grant;
    logic              pick_dm;
    logic              in_grant;
    logic              grant_start;
    logic              done;
    logic              expire;
    logic [DATA_W-1:0] rdata_q;

    assign pick_dm     = dm_req & (~if_req | (last_grant == GRANT_IF_ID));
    assign in_grant    = (state == GRANT_DM) | (state == GRANT_IF);
    assign grant_start = (state == IDLE) & (dm_req | if_req);
    assign done        = in_grant & mem_req & mem_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:               state_nx = pick_dm ? GRANT_DM : (if_req ? GRANT_IF : IDLE);
            GRANT_DM, GRANT_IF: state_nx = (done | expire) ? RESP : state;
            default:            state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= GRANT_IF_ID;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nx;
            if (grant_start) begin
                last_grant <= pick_dm ? GRANT_DM_ID : GRANT_IF_ID;
                mem_req    <= 1'b1;
                mem_we     <= pick_dm & dm_we;
                mem_addr   <= pick_dm ? dm_addr : if_addr;
                mem_wdata  <= pick_dm ? dm_wdata : '0;
            end
            if (done | expire) begin
                mem_req <= 1'b0;
                rdata_q <= done ? mem_rdata : DATA_W'(ERR_RDATA);
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clr   (grant_start),
        .en    (in_grant & ~mem_ready),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_err <= 1'b0;
        end else if (expire) begin
            timeout_err <= 1'b1;
        end
    end
`else
    // No watchdog: the grant waits for mem_ready forever.
    assign expire      = 1'b0 & (TIMEOUT_CYCLES > 0);
    assign timeout_err = 1'b0;
`endif

    // The ack belongs to whoever was granted last; rdata is masked outside the ack.
    assign if_ack   = (state == RESP) & (last_grant == GRANT_IF_ID);
    assign dm_ack   = (state == RESP) & (last_grant == GRANT_DM_ID);
    assign if_rdata = if_ack ? rdata_q : '0;
    assign dm_rdata = dm_ack ? rdata_q : '0;
    assign stall    = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule
